// File: rtl/bin_to_bcd_display.sv
// bin_to_bcd_display: sequential double-dabble binary-to-BCD converter, one input bit per clock,
// with a registered result held for the seven-segment driver between conversions.
module bin_to_bcd_display #(
  parameter int IN_WIDTH = 27,
  parameter int DIGITS   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_WIDTH-1:0]   bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd,
  output logic                  overflow
);
  localparam int BW = 4*DIGITS;
  localparam int CW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
  function automatic logic [63:0] pow10_m1(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int i = 0; i < n; i++) p = p * 64'd10;
    return p - 64'd1;
  endfunction
  localparam logic [63:0] MAX_DEC = pow10_m1(DIGITS);
  // Overflow only exists when the input range can exceed the largest displayable value.
  localparam bit OVF_EN = (IN_WIDTH < 64) && (MAX_DEC < ((64'd1 << IN_WIDTH) - 64'd1));
  localparam logic [IN_WIDTH-1:0] MAX_IN = IN_WIDTH'(MAX_DEC);
  typedef enum logic [1:0] {IDLE, SHIFT, FIN} state_t;
  state_t state_q, state_d;
  logic [IN_WIDTH-1:0] shift_q, shift_d;
  logic [BW-1:0] acc_q, acc_d, adj, bcd_q, bcd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic ovf_q, ovf_d, busy_q, busy_d, done_q, done_d, overflow_q, overflow_d;
  always_comb begin
    adj = acc_q;
    for (int i = 0; i < DIGITS; i++)
      adj[4*i +: 4] = acc_q[4*i +: 4] >= 4'd5 ? acc_q[4*i +: 4] + 4'd3 : acc_q[4*i +: 4];
  end
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    acc_d = acc_q;
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    busy_d = busy_q;
    done_d = 1'b0;
    bcd_d = bcd_q;
    overflow_d = overflow_q;
    case (state_q)
      IDLE: if (start) begin
        shift_d = bin;
        acc_d = '0;
        cnt_d = '0;
        ovf_d = OVF_EN && (bin > MAX_IN);
        busy_d = 1'b1;
        state_d = SHIFT;
      end
      SHIFT: begin
        {acc_d, shift_d} = {adj, shift_q} << 1;
        cnt_d = cnt_q + 1'b1;
        state_d = cnt_q == CW'(IN_WIDTH-1) ? FIN : SHIFT;
      end
      FIN: begin
        bcd_d = ovf_q ? {DIGITS{4'hE}} : acc_q;
        overflow_d = ovf_q;
        done_d = 1'b1;
        busy_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shift_q <= '0;
      acc_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      bcd_q <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      busy_q <= busy_d;
      done_q <= done_d;
      bcd_q <= bcd_d;
      overflow_q <= overflow_d;
    end
  end
  assign busy = busy_q;
  assign done = done_q;
  assign bcd = bcd_q;
  assign overflow = overflow_q;
endmodule
